// File: rtl/topk_readout_if.sv
// Host/search-core facing signal bundle for the top-k result collector.
// The slave modport is the collector's view; the master modport is the driver's view.
interface topk_readout_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_in;
    logic [15:0]           k_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid_in;
    logic                  rd_req_in;
    logic [DATA_WIDTH-1:0] rd_data_out;
    logic                  rd_valid_out;
    logic                  done_out;
    logic                  busy_out;
    logic [15:0]           count_out;
    logic [15:0]           query_id_out;
    logic                  overflow_out;

    modport slave (
        input  start_in, k_in, data_in, data_valid_in, rd_req_in,
        output rd_data_out, rd_valid_out, done_out, busy_out,
               count_out, query_id_out, overflow_out
    );

    modport master (
        output start_in, k_in, data_in, data_valid_in, rd_req_in,
        input  rd_data_out, rd_valid_out, done_out, busy_out,
               count_out, query_id_out, overflow_out
    );
endinterface

// File: rtl/topk_readout.sv
// Collects up to MAX_K result words per query from the search core and serves
// them to the host as header, results, then an all-ones sentinel, one word per request edge.
module topk_readout #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_K      = 8
) (
    input  logic          clk_in,
    input  logic          rst_in,
    topk_readout_if.slave bus
);

    localparam int IDX_W = (MAX_K > 1) ? $clog2(MAX_K) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_READY,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_buf [MAX_K];
    logic [15:0]           r_count;
    logic [15:0]           r_k_eff;
    logic [15:0]           r_rd_idx;
    logic [15:0]           r_qid;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rd_req_q;

    logic                  w_rd_evt;
    logic [15:0]           w_k_eff;
    logic [15:0]           w_count_inc;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_drain_entry;

    // Requested k saturated to the buffer depth.
    function automatic logic [15:0] sat_k(input logic [15:0] k);
        return (k > 16'(MAX_K)) ? 16'(MAX_K) : k;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] header_word(input logic [15:0] qid,
                                                          input logic [15:0] cnt);
        logic [DATA_WIDTH-1:0] w;
        w       = '0;
        w[31:0] = {qid, cnt};
        return w;
    endfunction

    assign w_rd_evt      = bus.rd_req_in & ~r_rd_req_q;
    assign w_k_eff       = sat_k(bus.k_in);
    assign w_count_inc   = r_count + 16'd1;
    // A start pulse owns the cycle: a coincident beat is neither stored nor flagged.
    assign w_accept      = (r_state == S_COLLECT) & bus.data_valid_in & ~bus.start_in;
    assign w_drop        = (r_state != S_COLLECT) & bus.data_valid_in & ~bus.start_in;
    assign w_drain_entry = (r_rd_idx < r_count);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.start_in) begin
            w_state_nxt = (w_k_eff == 16'd0) ? S_READY : S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: if (w_accept && (w_count_inc == r_k_eff)) w_state_nxt = S_READY;
                S_READY:   if (w_rd_evt) w_state_nxt = S_DRAIN;
                S_DRAIN:   if (w_rd_evt && !w_drain_entry) w_state_nxt = S_IDLE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_count    <= '0;
            r_k_eff    <= '0;
            r_rd_idx   <= '0;
            r_qid      <= '0;
            r_overflow <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_req_q <= 1'b0;
        end else begin
            r_rd_req_q <= bus.rd_req_in;
            if (bus.start_in) begin
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_k_eff    <= w_k_eff;
                r_rd_idx   <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                if (w_accept) r_count <= w_count_inc;
                if (w_drop)   r_overflow <= 1'b1;
                if (w_rd_evt) begin
                    case (r_state)
                        S_READY: begin
                            r_rd_data  <= header_word(r_qid, r_count);
                            r_rd_valid <= 1'b1;
                            r_rd_idx   <= '0;
                        end
                        S_DRAIN: begin
                            r_rd_valid <= 1'b1;
                            if (w_drain_entry) begin
                                r_rd_data <= r_buf[r_rd_idx[IDX_W-1:0]];
                                r_rd_idx  <= r_rd_idx + 16'd1;
                            end else begin
                                r_rd_data <= '1;
                                r_qid     <= r_qid + 16'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Result storage carries no reset; r_count alone defines which entries are live.
    always_ff @(posedge clk_in) begin
        if (w_accept) r_buf[r_count[IDX_W-1:0]] <= bus.data_in;
    end

    assign bus.rd_data_out  = r_rd_data;
    assign bus.rd_valid_out = r_rd_valid;
    assign bus.done_out     = (r_state == S_READY) || (r_state == S_DRAIN);
    assign bus.busy_out     = (r_state == S_COLLECT);
    assign bus.count_out    = r_count;
    assign bus.query_id_out = r_qid;
    assign bus.overflow_out = r_overflow;

endmodule

// File: tb/tb_topk_readout.sv
// Self-checking bench for topk_readout: directed scenarios plus randomized queries
// compared against a queue-based model of the framed result set.
module tb_topk_readout;

    localparam int DW   = 32;
    localparam int MAXK = 8;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   m_qid;

    topk_readout_if #(.DATA_WIDTH(DW)) bus ();

    topk_readout #(.DATA_WIDTH(DW), .MAX_K(MAXK)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input int k);
        bus.start_in = 1'b1;
        bus.k_in     = 16'(k);
        cyc();
        bus.start_in = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        bus.data_valid_in = 1'b1;
        bus.data_in       = d;
        cyc();
        bus.data_valid_in = 1'b0;
    endtask

    task automatic read_word(input int hold, output logic [31:0] d, output logic v);
        bus.rd_req_in = 1'b1;
        cyc();
        d = bus.rd_data_out;
        v = bus.rd_valid_out;
        repeat (hold - 1) cyc();
        bus.rd_req_in = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_in = 1'b0; bus.k_in = '0; bus.data_in = '0;
        bus.data_valid_in = 1'b0; bus.rd_req_in = 1'b0;
        repeat (3) cyc();
        n_total++; if (bus.done_out !== 1'b0) $display("FAIL reset_done: got %0b want 0", bus.done_out); else n_pass++;
        n_total++; if (bus.busy_out !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy_out); else n_pass++;
        n_total++; if (bus.count_out !== 16'd0) $display("FAIL reset_count: got %0d want 0", bus.count_out); else n_pass++;
        n_total++; if (bus.rd_valid_out !== 1'b0) $display("FAIL reset_rdvalid: got %0b want 0", bus.rd_valid_out); else n_pass++;
        n_total++; if (bus.query_id_out !== 16'd0) $display("FAIL reset_qid: got %0d want 0", bus.query_id_out); else n_pass++;
        rst_n = 1'b1;
        cyc();
        m_qid = 0;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp [6];
        exp = '{32'h0000_0004, 32'd5, 32'd7, 32'd1, 32'd1, 32'hFFFF_FFFF};
        do_start(4);
        n_total++; if (bus.busy_out !== 1'b1) $display("FAIL basic_busy: got %0b want 1", bus.busy_out); else n_pass++;
        beat(32'd5);
        n_total++; if (bus.count_out !== 16'd1) $display("FAIL basic_count1: got %0d want 1", bus.count_out); else n_pass++;
        beat(32'd7); beat(32'd1); beat(32'd1);
        n_total++; if (bus.done_out !== 1'b1) $display("FAIL basic_done: got %0b want 1", bus.done_out); else n_pass++;
        n_total++; if (bus.count_out !== 16'd4) $display("FAIL basic_count: got %0d want 4", bus.count_out); else n_pass++;
        n_total++; if (bus.busy_out !== 1'b0) $display("FAIL basic_busy_end: got %0b want 0", bus.busy_out); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            read_word(1, d, v);
            n_total++; if (d !== exp[i] || v !== 1'b1) $display("FAIL basic_read%0d: got %h/%0b want %h/1", i, d, v, exp[i]); else n_pass++;
        end
        m_qid++;
        n_total++; if (bus.query_id_out !== 16'(m_qid)) $display("FAIL basic_qid: got %0d want %0d", bus.query_id_out, m_qid); else n_pass++;
        n_total++; if (bus.done_out !== 1'b0) $display("FAIL basic_idle: got %0b want 0", bus.done_out); else n_pass++;
    endtask

    task automatic test_kmax();
        logic [31:0] d;
        logic        v;
        logic [31:0] vals[$];
        do_start(20);
        for (int i = 0; i < MAXK; i++) begin
            vals.push_back($urandom);
            beat(vals[i]);
        end
        n_total++; if (bus.done_out !== 1'b1) $display("FAIL kmax_done: got %0b want 1", bus.done_out); else n_pass++;
        n_total++; if (bus.overflow_out !== 1'b0) $display("FAIL kmax_noovf: got %0b want 0", bus.overflow_out); else n_pass++;
        beat(32'hDEAD_BEEF);
        n_total++; if (bus.overflow_out !== 1'b1) $display("FAIL kmax_ovf: got %0b want 1", bus.overflow_out); else n_pass++;
        n_total++; if (bus.count_out !== 16'd8) $display("FAIL kmax_count: got %0d want 8", bus.count_out); else n_pass++;
        read_word(1, d, v);
        n_total++; if (d !== {16'(m_qid), 16'd8}) $display("FAIL kmax_header: got %h want %h", d, {16'(m_qid), 16'd8}); else n_pass++;
        for (int i = 0; i < MAXK; i++) begin
            read_word(1, d, v);
            n_total++; if (d !== vals[i]) $display("FAIL kmax_entry%0d: got %h want %h", i, d, vals[i]); else n_pass++;
        end
        read_word(1, d, v);
        n_total++; if (d !== 32'hFFFF_FFFF) $display("FAIL kmax_sentinel: got %h want ffffffff", d); else n_pass++;
        m_qid++;
    endtask

    task automatic test_kzero();
        logic [31:0] d;
        logic        v;
        do_start(0);
        n_total++; if (bus.done_out !== 1'b1) $display("FAIL kzero_done: got %0b want 1", bus.done_out); else n_pass++;
        read_word(1, d, v);
        n_total++; if (d !== {16'(m_qid), 16'd0}) $display("FAIL kzero_header: got %h want %h", d, {16'(m_qid), 16'd0}); else n_pass++;
        read_word(1, d, v);
        n_total++; if (d !== 32'hFFFF_FFFF) $display("FAIL kzero_sentinel: got %h want ffffffff", d); else n_pass++;
        m_qid++;
        n_total++; if (bus.done_out !== 1'b0 || bus.busy_out !== 1'b0) $display("FAIL kzero_idle: got done=%0b busy=%0b want 0/0", bus.done_out, bus.busy_out); else n_pass++;
    endtask

    task automatic test_hold();
        logic [31:0] d;
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom; b = $urandom;
        do_start(2);
        n_total++; if (bus.rd_valid_out !== 1'b0) $display("FAIL hold_startclr: got %0b want 0", bus.rd_valid_out); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            read_word(1, d, v);
            n_total++; if (v !== 1'b0) $display("FAIL hold_collect_rd%0d: got %0b want 0", i, v); else n_pass++;
        end
        beat(a); beat(b);
        bus.rd_req_in = 1'b1;
        repeat (10) cyc();
        n_total++; if (bus.rd_data_out !== {16'(m_qid), 16'd2} || bus.rd_valid_out !== 1'b1)
            $display("FAIL hold_header: got %h/%0b want %h/1", bus.rd_data_out, bus.rd_valid_out, {16'(m_qid), 16'd2}); else n_pass++;
        bus.rd_req_in = 1'b0;
        cyc();
        read_word(1, d, v);
        n_total++; if (d !== a) $display("FAIL hold_first: got %h want %h", d, a); else n_pass++;
        read_word(3, d, v);
        n_total++; if (d !== b) $display("FAIL hold_second: got %h want %h", d, b); else n_pass++;
        read_word(1, d, v);
        n_total++; if (d !== 32'hFFFF_FFFF) $display("FAIL hold_sentinel: got %h want ffffffff", d); else n_pass++;
        m_qid++;
    endtask

    task automatic test_start_mid_drain();
        logic [31:0] d;
        logic        v;
        logic [31:0] vals[$];
        do_start(4);
        for (int i = 0; i < 4; i++) beat($urandom);
        read_word(1, d, v);
        read_word(1, d, v);
        read_word(1, d, v);
        do_start(3);
        n_total++; if (bus.rd_valid_out !== 1'b0) $display("FAIL mid_rdvalid: got %0b want 0", bus.rd_valid_out); else n_pass++;
        n_total++; if (bus.count_out !== 16'd0) $display("FAIL mid_count: got %0d want 0", bus.count_out); else n_pass++;
        n_total++; if (bus.busy_out !== 1'b1) $display("FAIL mid_busy: got %0b want 1", bus.busy_out); else n_pass++;
        n_total++; if (bus.query_id_out !== 16'(m_qid)) $display("FAIL mid_qid: got %0d want %0d", bus.query_id_out, m_qid); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            vals.push_back($urandom);
            beat(vals[i]);
        end
        read_word(1, d, v);
        n_total++; if (d !== {16'(m_qid), 16'd3}) $display("FAIL mid_header: got %h want %h", d, {16'(m_qid), 16'd3}); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            read_word(1, d, v);
            n_total++; if (d !== vals[i]) $display("FAIL mid_entry%0d: got %h want %h", i, d, vals[i]); else n_pass++;
        end
        read_word(1, d, v);
        m_qid++;
        n_total++; if (bus.query_id_out !== 16'(m_qid)) $display("FAIL mid_qid_end: got %0d want %0d", bus.query_id_out, m_qid); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_q[$];
        int k, keff, extra, sent;
        for (int q = 0; q < 8; q++) begin
            k     = int'($urandom_range(0, 12));
            keff  = (k > MAXK) ? MAXK : k;
            extra = int'($urandom_range(0, 2));
            exp_q = {};
            sent  = 0;
            do_start(k);
            exp_q.push_back({16'(m_qid), 16'(keff)});
            for (int i = 0; i < keff + extra; i++) begin
                d = $urandom;
                if (i < keff) exp_q.push_back(d);
                beat(d);
                sent++;
                repeat ($urandom_range(0, 2)) cyc();
            end
            exp_q.push_back(32'hFFFF_FFFF);
            n_total++; if (bus.done_out !== 1'b1 || bus.count_out !== 16'(keff))
                $display("FAIL rnd%0d_done: got done=%0b cnt=%0d want 1/%0d", q, bus.done_out, bus.count_out, keff); else n_pass++;
            n_total++; if (bus.overflow_out !== (sent > keff))
                $display("FAIL rnd%0d_ovf: got %0b want %0b", q, bus.overflow_out, (sent > keff)); else n_pass++;
            while (exp_q.size() > 0) begin
                read_word(int'($urandom_range(1, 3)), d, v);
                n_total++; if (d !== exp_q[0] || v !== 1'b1)
                    $display("FAIL rnd%0d_word: got %h/%0b want %h/1", q, d, v, exp_q[0]); else n_pass++;
                void'(exp_q.pop_front());
            end
            m_qid++;
            n_total++; if (bus.query_id_out !== 16'(m_qid) || bus.done_out !== 1'b0)
                $display("FAIL rnd%0d_end: got qid=%0d done=%0b want %0d/0", q, bus.query_id_out, bus.done_out, m_qid); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        do_start(4);
        beat(32'h1234_5678);
        beat(32'h9ABC_DEF0);
        n_total++; if (bus.busy_out !== 1'b1) $display("FAIL arst_pre_busy: got %0b want 1", bus.busy_out); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0)
            $display("FAIL arst_state: got busy=%0b done=%0b want 0/0", bus.busy_out, bus.done_out); else n_pass++;
        n_total++; if (bus.count_out !== 16'd0 || bus.query_id_out !== 16'd0)
            $display("FAIL arst_counters: got cnt=%0d qid=%0d want 0/0", bus.count_out, bus.query_id_out); else n_pass++;
        n_total++; if (bus.rd_data_out !== 32'd0 || bus.rd_valid_out !== 1'b0 || bus.overflow_out !== 1'b0)
            $display("FAIL arst_outputs: got data=%h v=%0b ovf=%0b want 0/0/0", bus.rd_data_out, bus.rd_valid_out, bus.overflow_out); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        n_total++; if (bus.busy_out !== 1'b0) $display("FAIL arst_post_idle: got %0b want 0", bus.busy_out); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_kmax();
        test_kzero();
        test_hold();
        test_start_mid_drain();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
